// File: rtl/mic_ram_pkg.sv
// mic_ram_pkg: shared definitions for the mic_ram_writer capture stage.
//   - CSR word addresses
//   - CTRL / STATUS bit positions
//   - writer FSM state encoding
//   - width of the dropped-sample counter
package mic_ram_pkg;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_STATUS = 2'd1;
  localparam logic [1:0] CSR_WRPTR  = 2'd2;
  localparam logic [1:0] CSR_DROPS  = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_HALF0   = 0;
  localparam int ST_HALF1   = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_ACTIVE  = 3;

  localparam int DROPS_W       = 16;
  localparam int DROPS_CLR_BIT = 31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/mic_ram_writer_csr.sv
// mic_ram_writer_csr: register file for the capture stage.
//   CTRL (RW), STATUS (W1C flags + RO active), WRPTR (RO), DROPS (RO).
//   Hardware set of a STATUS flag wins over a simultaneous W1C.
//   Read data is registered (1-cycle latency) and held between reads.
//   irq is registered from the flags, so it follows a flag by one cycle.
// Optional: MIC_RAM_WRITER_DROP_CNT_EN builds the 16-bit saturating DROPS
//   counter and its clear bit (bit 31 of a CSR 3 write); otherwise CSR 3
//   reads 0.
// Ports:
//   clk, reset                 clock, async active-high reset
//   csr_address/read/write/writedata/readdata   CSR slave
//   set_half0, set_half1, set_overrun          hardware flag set pulses
//   inc_drop                   one sample discarded this cycle
//   active, wrptr              live status from the writer
//   enable, irq_en             CTRL fields
//   half0_full, half1_full     STATUS flags consumed by the writer FSM
//   irq                        level interrupt
module mic_ram_writer_csr
  import mic_ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic              set_half0,
  input  logic              set_half1,
  input  logic              set_overrun,
  input  logic              inc_drop,
  input  logic              active,
  input  logic [ADDR_W-1:0] wrptr,
  output logic              enable,
  output logic              half0_full,
  output logic              half1_full,
  output logic              irq
);

  logic        irq_en;
  logic        overrun;
  logic [2:0]  w1c;
  logic [31:0] drops_rd;
  logic [31:0] rd_mux;

  always_comb begin
    w1c = 3'b000;
    if (csr_write && csr_address == CSR_STATUS) w1c = csr_writedata[2:0];
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_CTRL:   rd_mux = {30'b0, irq_en, enable};
      CSR_STATUS: rd_mux = {28'b0, active, overrun, half1_full, half0_full};
      CSR_WRPTR:  rd_mux = 32'(wrptr);
      CSR_DROPS:  rd_mux = drops_rd;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      half0_full   <= 1'b0;
      half1_full   <= 1'b0;
      overrun      <= 1'b0;
      irq          <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (csr_write && csr_address == CSR_CTRL) begin
        enable <= csr_writedata[CTRL_ENABLE];
        irq_en <= csr_writedata[CTRL_IRQ_EN];
      end
      // set term ORed last so a same-cycle set survives the clear
      half0_full <= set_half0   | (half0_full & ~w1c[ST_HALF0]);
      half1_full <= set_half1   | (half1_full & ~w1c[ST_HALF1]);
      overrun    <= set_overrun | (overrun    & ~w1c[ST_OVERRUN]);
      irq        <= irq_en & (half0_full | half1_full | overrun);
      if (csr_read) csr_readdata <= rd_mux;
    end
  end

`ifdef MIC_RAM_WRITER_DROP_CNT_EN
  logic [DROPS_W-1:0] drops;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drops <= '0;
    end else if (csr_write && csr_address == CSR_DROPS && csr_writedata[DROPS_CLR_BIT]) begin
      drops <= '0;
    end else if (inc_drop && drops != {DROPS_W{1'b1}}) begin
      drops <= drops + 1'b1;
    end
  end

  assign drops_rd = 32'(drops);

  logic unused_wdata;
  assign unused_wdata = ^csr_writedata[30:3];
`else
  assign drops_rd = '0;

  logic unused_wdata;
  assign unused_wdata = ^{csr_writedata[31:3], inc_drop};
`endif

endmodule

// File: rtl/mic_ram_writer.sv
// mic_ram_writer: streams 32-bit microphone samples into port 2 of a
// dual-port RAM used as a two-half ping-pong buffer. Completing a half sets
// its full flag; entering a half whose flag is still set flags overrun and
// discards samples until the processor releases that half.
// Optional: MIC_RAM_WRITER_DROP_CNT_EN (see mic_ram_writer_csr).
// Ports:
//   clk, reset                       clock, async active-high reset
//   snk_valid/snk_data/snk_ready     sample stream; a sample transfers on
//                                    any cycle with snk_valid & snk_ready,
//                                    and snk_ready never depends on snk_valid
//   address2/writedata2/byteenable2/chipselect2/write2/clken2  RAM port 2
//   csr_*                            CSR slave (see mic_ram_writer_csr)
//   irq                              level interrupt
//   fsm_state                        writer FSM state for observation
module mic_ram_writer
  import mic_ram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                snk_valid,
  input  logic [DATA_W-1:0]   snk_data,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   address2,
  output logic [DATA_W-1:0]   writedata2,
  output logic [DATA_W/8-1:0] byteenable2,
  output logic                chipselect2,
  output logic                write2,
  output logic                clken2,
  input  logic [1:0]          csr_address,
  input  logic                csr_read,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  output logic [31:0]         csr_readdata,
  output logic                irq,
  output wr_state_e           fsm_state
);

  localparam logic [ADDR_W-2:0] HALF_LAST = '1;

  wr_state_e         state;
  logic [ADDR_W-1:0] wrptr;
  logic [ADDR_W-1:0] wrptr_inc;
  logic              enable_q;
  logic              enable;
  logic              half0_full;
  logic              half1_full;
  logic              start;
  logic              fill_acc;
  logic              at_half_end;
  logic              next_half_full;
  logic              cur_half_full;
  logic              set_half0;
  logic              set_half1;
  logic              set_overrun;
  logic              inc_drop;

  assign snk_ready   = (state != S_IDLE);
  assign fsm_state   = state;
  assign chipselect2 = write2;
  assign byteenable2 = '1;
  assign clken2      = 1'b1;

  assign start          = enable & ~enable_q;
  assign fill_acc       = (state == S_FILL) & snk_valid;
  assign wrptr_inc      = wrptr + 1'b1;
  assign at_half_end    = (wrptr[ADDR_W-2:0] == HALF_LAST);
  // the half being entered after the last word of the current one
  assign next_half_full = wrptr_inc[ADDR_W-1] ? half1_full : half0_full;
  assign cur_half_full  = wrptr[ADDR_W-1] ? half1_full : half0_full;

  assign set_half0   = write2 & ~address2[ADDR_W-1] & (address2[ADDR_W-2:0] == HALF_LAST);
  assign set_half1   = write2 &  address2[ADDR_W-1] & (address2[ADDR_W-2:0] == HALF_LAST);
  assign set_overrun = enable & ((start & half0_full) |
                                 (~start & fill_acc & at_half_end & next_half_full));
  assign inc_drop    = (state == S_DROP) & snk_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wrptr      <= '0;
      enable_q   <= 1'b0;
      write2     <= 1'b0;
      address2   <= '0;
      writedata2 <= '0;
    end else begin
      enable_q <= enable;

      // a sample accepted in FILL is always written, even if the block is
      // being disabled in the same cycle
      write2 <= 1'b0;
      if (fill_acc) begin
        write2     <= 1'b1;
        address2   <= wrptr;
        writedata2 <= snk_data;
      end

      if (start)         wrptr <= '0;
      else if (fill_acc) wrptr <= wrptr_inc;

      if (!enable) begin
        state <= S_IDLE;
      end else if (start) begin
        state <= half0_full ? S_DROP : S_FILL;
      end else begin
        case (state)
          S_FILL:  if (fill_acc && at_half_end && next_half_full) state <= S_DROP;
          S_DROP:  if (!cur_half_full) state <= S_FILL;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  mic_ram_writer_csr #(.ADDR_W(ADDR_W)) u_csr (
    .clk           (clk),
    .reset         (reset),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .set_half0     (set_half0),
    .set_half1     (set_half1),
    .set_overrun   (set_overrun),
    .inc_drop      (inc_drop),
    .active        (state != S_IDLE),
    .wrptr         (wrptr),
    .enable        (enable),
    .half0_full    (half0_full),
    .half1_full    (half1_full),
    .irq           (irq)
  );

endmodule

// File: doc/mic_ram_writer.md
# mic_ram_writer

Streaming capture stage that writes incoming 32-bit microphone sample words into port 2 of the 1024×32 dual-port on-chip RAM, treating it as a two-half ping-pong buffer. The Nios processor reads completed halves through RAM port 1. The block raises a level interrupt when a half is full. If the processor has not released a half before the writer needs it again, the writer drops samples and counts them.

## Interface
- ADDR_W, 10, RAM word-address width; buffer depth is 2^ADDR_W; half size is 2^(ADDR_W-1).
- DATA_W, 32, sample and RAM data width.
- clk  in  1  single clock for all logic; drives the RAM clock.
- reset  in  1  asynchronous, active-high.
- snk_valid  in  1  sample present.
- snk_data  in  DATA_W  sample word.
- snk_ready  out  1  sample accepted when snk_valid & snk_ready.
- address2  out  ADDR_W  RAM port-2 word address.
- writedata2  out  DATA_W  RAM port-2 write data.
- byteenable2  out  DATA_W/8  RAM byte enables; constant all-ones.
- chipselect2, write2  out  1 each  RAM port-2 write strobe; both driven identically.
- clken2  out  1  RAM port-2 clock enable; constant 1.
- csr_address  in  2  CSR word select.
- csr_read, csr_write  in  1 each  CSR strobes.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data.
- irq  out  1  level interrupt to the Nios processor.

## Operation
- CSR 0, CTRL (RW):
  - bit0 enable.
  - bit1 irq_en.
- CSR 1, STATUS:
  - bit0 half0_full (W1C).
  - bit1 half1_full (W1C).
  - bit2 overrun (W1C).
  - bit3 active (RO).
- CSR 2, WRPTR (RO): current write address, zero-extended.
- CSR 3, DROPS (RO): 16-bit saturating count of dropped samples.
- Writing 1 to bit 31 of CSR 3 clears the count.
- States:
  - IDLE: snk_ready=0, no writes.
  - FILL: snk_ready=1; each accepted sample is written to wrptr, then wrptr increments.
  - DROP: snk_ready=1; accepted samples are discarded and DROPS increments.
- IDLE→FILL on the enable 0→1 transition; wrptr is cleared to 0 on this transition.
- FILL or DROP→IDLE whenever enable=0, taking effect the next cycle. A write already registered still completes.
- The write to the last word of a half (address 511 or 1023) sets the corresponding halfN_full flag.
- wrptr wraps from 1023 to 0.
- When wrptr enters a half whose flag is still set:
  - set overrun and go to DROP;
  - stay in DROP until that flag is cleared;
  - then return to FILL at the half's base address.
- The half-entry check also applies when FILL starts at address 0 while half0_full=1.
- Simultaneous hardware set and CSR W1C of the same flag: the set wins.
- irq = irq_en & (half0_full | half1_full | overrun).

## Timing
- Write latency: a sample accepted in cycle N produces write2=1 with its address and data in cycle N+1. There is at most one write per cycle, and throughput is one sample per cycle.
- CSR read latency: 1 cycle, registered. csr_readdata holds its value between reads.
- CSR writes take effect the next cycle.
- irq is registered and asserts 1 cycle after the flag sets.
- Reset values:
  - all CSRs 0, wrptr 0, state IDLE;
  - snk_ready, write2, chipselect2, irq, csr_readdata = 0;
  - address2 and writedata2 = 0;
  - byteenable2 all-ones, clken2 = 1.
- Reset asserted mid-fill forces write2=0 immediately (asynchronous). No partial state survives reset.

## Configuration
- MIC_RAM_WRITER_DROP_CNT_EN defined: the DROPS counter and its clear bit are implemented.
- Macro undefined: the counter logic is removed and CSR 3 reads 0. Overrun flagging and DROP-state behaviour are unchanged.

## Structure
- Package mic_ram_pkg holds:
  - CSR address constants;
  - STATUS and CTRL bit positions;
  - the state enum (IDLE/FILL/DROP);
  - the DROPS width constant.
- One natural sub-module, mic_ram_writer_csr: register file, W1C and set-priority logic, readdata mux, irq register. The datapath and FSM stay in the top module.

## Test plan
- Enable, stream 512 back-to-back samples 0..511 → RAM[0..511]=0..511; half0_full=1 one cycle after the write of 511; irq=1 with irq_en set.
- Stream 1024 samples without clearing flags, then 3 more → samples 1024..1026 dropped; overrun=1; DROPS=3; RAM[0..2] unchanged.
- From the DROP state, W1C half0_full → the next sample is written to address 0; state is FILL.
- W1C of half1_full in the same cycle as the write to address 1023 → half1_full remains 1.
- Disable after 100 samples, then re-enable → the next sample goes to address 0; the WRPTR read returns 0.
- Assert reset during a streaming burst → write2 drops to 0 in the same cycle; all CSR reads return 0 after release.
